// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port between two writeback sources.
//   Port A (ALU pipe) and port B (LSU / multi-cycle unit) each feed a one-entry
//   holding register through a valid/ready handshake. A round-robin grant picks
//   one valid hold per cycle and loads a registered write stage that drives the
//   regfile write enable/address/data. Writes to x0 complete their handshake
//   but never raise the write enable. A pending-write mask lets decode stall on
//   registers whose writes are still in flight, and a saturating counter
//   tracks how often both sources compete.
//
// Ports:
//   clk, rst                      clock (rising edge) / async active-high reset
//   a_valid, a_ready              port A handshake
//   a_waddr, a_wdata              port A destination register and data
//   b_valid, b_ready              port B handshake
//   b_waddr, b_wdata              port B destination register and data
//   rf_wen, rf_waddr, rf_wdata    registered regfile write port
//   pend_mask                     bit i set while a write to reg i is in flight
//   clr_cnt                       synchronous clear of conflict_cnt
//   conflict_cnt                  saturating count of cycles with both holds valid
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [ADDR_W-1:0]        a_waddr,
  input  logic [DATA_W-1:0]        a_wdata,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [ADDR_W-1:0]        b_waddr,
  input  logic [DATA_W-1:0]        b_wdata,
  output logic                     rf_wen,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [(1<<ADDR_W)-1:0]   pend_mask,
  input  logic                     clr_cnt,
  output logic [CNT_W-1:0]         conflict_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic              holdVldA_q, holdVldA_d;
  logic [ADDR_W-1:0] holdAddrA_q, holdAddrA_d;
  logic [DATA_W-1:0] holdDataA_q, holdDataA_d;
  logic              holdVldB_q, holdVldB_d;
  logic [ADDR_W-1:0] holdAddrB_q, holdAddrB_d;
  logic [DATA_W-1:0] holdDataB_q, holdDataB_d;

  // 1 when port B received the most recent grant; the other port wins the next tie.
  logic              lastGrantB_q, lastGrantB_d;

  logic              rfWen_q, rfWen_d;
  logic [ADDR_W-1:0] rfWaddr_q, rfWaddr_d;
  logic [DATA_W-1:0] rfWdata_q, rfWdata_d;
  logic [CNT_W-1:0]  conflictCnt_q, conflictCnt_d;

  logic              grantA, grantB, grantAny;
  logic              acceptA, acceptB;
  logic [ADDR_W-1:0] winAddr;
  logic [DATA_W-1:0] winData;
  logic [NREG-1:0]   pendMask;

  // Round-robin grant: a lone valid hold always wins, a tie goes to the port
  // that did not win last time.
  always_comb begin
    grantA   = holdVldA_q & (~holdVldB_q | lastGrantB_q);
    grantB   = holdVldB_q & (~holdVldA_q | ~lastGrantB_q);
    grantAny = grantA | grantB;
    winAddr  = grantA ? holdAddrA_q : holdAddrB_q;
    winData  = grantA ? holdDataA_q : holdDataB_q;
  end

  // A hold can take a new entry in the same cycle its current entry drains,
  // which is what allows a single port to stream one write per cycle.
  assign a_ready = ~holdVldA_q | grantA;
  assign b_ready = ~holdVldB_q | grantB;
  assign acceptA = a_valid & a_ready;
  assign acceptB = b_valid & b_ready;

  // Next-state for holds, grant history, write stage and conflict counter.
  always_comb begin
    holdVldA_d    = holdVldA_q;
    holdAddrA_d   = holdAddrA_q;
    holdDataA_d   = holdDataA_q;
    holdVldB_d    = holdVldB_q;
    holdAddrB_d   = holdAddrB_q;
    holdDataB_d   = holdDataB_q;
    lastGrantB_d  = lastGrantB_q;
    rfWaddr_d     = rfWaddr_q;
    rfWdata_d     = rfWdata_q;
    conflictCnt_d = conflictCnt_q;

    if (acceptA) begin
      holdVldA_d  = 1'b1;
      holdAddrA_d = a_waddr;
      holdDataA_d = a_wdata;
    end else if (grantA) begin
      holdVldA_d  = 1'b0;
    end

    if (acceptB) begin
      holdVldB_d  = 1'b1;
      holdAddrB_d = b_waddr;
      holdDataB_d = b_wdata;
    end else if (grantB) begin
      holdVldB_d  = 1'b0;
    end

    if (grantAny) begin
      lastGrantB_d = grantB;
      rfWaddr_d    = winAddr;
      rfWdata_d    = winData;
    end

    // x0 writes drain through the arbiter but are dropped here.
    rfWen_d = grantAny & (winAddr != '0);

    if (clr_cnt) begin
      conflictCnt_d = '0;
    end else if (holdVldA_q & holdVldB_q & (conflictCnt_q != '1)) begin
      conflictCnt_d = conflictCnt_q + CNT_W'(1);
    end
  end

  // State registers; reset discards any held or staged write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdVldA_q    <= 1'b0;
      holdAddrA_q   <= '0;
      holdDataA_q   <= '0;
      holdVldB_q    <= 1'b0;
      holdAddrB_q   <= '0;
      holdDataB_q   <= '0;
      lastGrantB_q  <= 1'b1;
      rfWen_q       <= 1'b0;
      rfWaddr_q     <= '0;
      rfWdata_q     <= '0;
      conflictCnt_q <= '0;
    end else begin
      holdVldA_q    <= holdVldA_d;
      holdAddrA_q   <= holdAddrA_d;
      holdDataA_q   <= holdDataA_d;
      holdVldB_q    <= holdVldB_d;
      holdAddrB_q   <= holdAddrB_d;
      holdDataB_q   <= holdDataB_d;
      lastGrantB_q  <= lastGrantB_d;
      rfWen_q       <= rfWen_d;
      rfWaddr_q     <= rfWaddr_d;
      rfWdata_q     <= rfWdata_d;
      conflictCnt_q <= conflictCnt_d;
    end
  end

  // Pending mask covers both holds and the write stage; x0 is never pending.
  always_comb begin
    pendMask = '0;
    if (holdVldA_q) pendMask[holdAddrA_q] = 1'b1;
    if (holdVldB_q) pendMask[holdAddrB_q] = 1'b1;
    if (rfWen_q)    pendMask[rfWaddr_q]   = 1'b1;
    pendMask[0] = 1'b0;
  end

  assign pend_mask    = pendMask;
  assign rf_wen       = rfWen_q;
  assign rf_waddr     = rfWaddr_q;
  assign rf_wdata     = rfWdata_q;
  assign conflict_cnt = conflictCnt_q;

endmodule
